mul_8x8_seq: RTL and testbench
==============================

MUL_8X8_SEQ -- requirements
Module: mul_8x8_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit: requester presents operands.
REQ-005 Port in_ready, output, 1 bit: block can accept operands.
REQ-006 Port a, input, 8 bits: unsigned multiplicand.
REQ-007 Port b, input, 8 bits: unsigned multiplier.
REQ-008 Port out_valid, output, 1 bit: product is valid.
REQ-009 Port out_ready, input, 1 bit: consumer accepts product.
REQ-010 Port product, output, 16 bits: registered unsigned result a*b.
REQ-011 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 The block SHALL compute an exact unsigned 8x8 product by time-multiplexing a single 4x4 exact multiplier over four steps.
REQ-013 The state machine SHALL have states IDLE, MUL and DONE, with a 2-bit step counter used in MUL.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 On an input handshake (in_valid & in_ready), the block SHALL latch a and b, clear the 16-bit accumulator, set step=0 and enter MUL.
REQ-016 MUL step k SHALL add the following to the accumulator: k=0 a[3:0]*b[3:0]<<0; k=1 a[7:4]*b[3:0]<<4; k=2 a[3:0]*b[7:4]<<4; k=3 a[7:4]*b[7:4]<<8.
REQ-017 The accumulator SHALL be 16 bits with no carry out, since the maximum product is 0xFE01.
REQ-018 On step 3, the block SHALL load the final sum into the product register and enter DONE; out_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-019 In DONE, product and out_valid SHALL hold stable until out_valid & out_ready; on that edge the block SHALL enter IDLE.
REQ-020 After leaving DONE, product SHALL retain the last result until the next DONE entry.
REQ-021 a, b and in_valid SHALL be ignored outside IDLE; operand changes during MUL SHALL NOT affect the result.
REQ-022 The next request SHALL be accepted no earlier than the cycle after the output handshake, giving a minimum of 6 cycles per operation.
REQ-023 in_valid held high in IDLE SHALL be accepted on the first IDLE cycle.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE, step=0, accumulator=0, product=0 and latched operands=0.
REQ-025 Out of reset, outputs SHALL be in_ready=1, out_valid=0, busy=0, product=0x0000.
REQ-026 Reset asserted in MUL or DONE SHALL abandon the operation: no out_valid pulse, and IDLE on the next cycle.
REQ-027 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-028 The shared package mul_seq_pkg SHALL hold the state encodings (IDLE=2'b00, MUL=2'b01, DONE=2'b10), W_OP=8, W_NIB=4 and N_STEPS=4.
REQ-029 The block SHALL contain exactly one sub-module, a mul_4x4_exact instance, fed by a step-indexed nibble mux.
REQ-030 Shift, add and control logic SHALL be local; there SHALL be no second multiplier instance.

Verification
REQ-031 Reset: assert rst 2 cycles, release -> in_ready=1, out_valid=0, busy=0, product=0x0000.
REQ-032 a=0xFF, b=0xFF, out_ready=1 -> out_valid exactly 4 edges after accept, product=0xFE01; IDLE one cycle later.
REQ-033 a=0x12, b=0x34; change a/b to 0xAA/0x55 during MUL -> product=0x03A8.
REQ-034 a=0x0F, b=0xF0, out_ready=0 for 10 cycles -> product=0x0E10 stable, out_valid=1, in_ready=0, in_valid ignored; release -> IDLE.
REQ-035 Reset during step 2 of a=0xFF, b=0x02 -> IDLE next cycle, no out_valid; then a=0x00, b=0xA5 -> product=0x0000.
REQ-036 Back-to-back with in_valid and out_ready tied high: 0x10*0x10 then 0x80*0x02 -> 0x0100 then 0x0100, second accept one cycle after the first output handshake.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared constants, state encodings and operand payload for the sequential 8x8 multiplier.
package mul_seq_pkg;

  localparam int unsigned W_OP    = 8;
  localparam int unsigned W_NIB   = 4;
  localparam int unsigned N_STEPS = 4;
  localparam int unsigned W_STEP  = 2;
  localparam int unsigned W_PROD  = 2 * W_OP;
  localparam int unsigned W_PP    = 2 * W_NIB;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef struct packed {
    logic [W_OP-1:0] a;
    logic [W_OP-1:0] b;
  } operands_t;

endpackage

// File: rtl/mul_4x4_exact.sv
// Exact unsigned 4x4 combinational multiplier, the single shared partial-product unit.
module mul_4x4_exact
  import mul_seq_pkg::*;
(
  input  logic [W_NIB-1:0] x,
  input  logic [W_NIB-1:0] y,
  output logic [W_PP-1:0]  p_c
);

  assign p_c = W_PP'(x) * W_PP'(y);

endmodule

// File: rtl/mul_8x8_seq.sv
// Unsigned 8x8 multiplier built from one 4x4 multiplier stepped over four nibble pairs,
// with valid/ready handshakes on both sides.
module mul_8x8_seq
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_OP-1:0]   a,
  input  logic [W_OP-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_PROD-1:0] product,
  output logic              busy
);

  localparam logic [W_STEP-1:0] LAST_STEP = W_STEP'(N_STEPS - 1);

  logic [1:0]        state, state_nxt;
  logic [W_STEP-1:0] step, step_nxt;
  operands_t         ops, ops_nxt;
  logic [W_PROD-1:0] acc, acc_nxt;
  logic [W_PROD-1:0] product_nxt;
  logic              in_ready_nxt, out_valid_nxt, busy_nxt;

  logic [W_NIB-1:0]  nib_a_c, nib_b_c;
  logic [W_PP-1:0]   pp_c;
  logic [W_PROD-1:0] term_c, sum_c;

  // step[0] picks the high nibble of a, step[1] the high nibble of b
  always_comb begin
    nib_a_c = step[0] ? ops.a[W_OP-1:W_NIB] : ops.a[W_NIB-1:0];
    nib_b_c = step[1] ? ops.b[W_OP-1:W_NIB] : ops.b[W_NIB-1:0];
  end

  mul_4x4_exact u_mul (
    .x   (nib_a_c),
    .y   (nib_b_c),
    .p_c (pp_c)
  );

  // Partial-product weight is 4 bits per high nibble involved; max sum 0xFE01 never carries out
  always_comb begin
    unique case (step)
      2'd0:    term_c = W_PROD'(pp_c);
      2'd1,
      2'd2:    term_c = W_PROD'(pp_c) << W_NIB;
      default: term_c = W_PROD'(pp_c) << (2 * W_NIB);
    endcase
    sum_c = acc + term_c;
  end

  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    ops_nxt     = ops;
    acc_nxt     = acc;
    product_nxt = product;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          ops_nxt   = '{a: a, b: b};
          acc_nxt   = '0;
          step_nxt  = '0;
          state_nxt = MUL;
        end
      end
      MUL: begin
        acc_nxt  = sum_c;
        step_nxt = step + W_STEP'(1);
        if (step == LAST_STEP) begin
          product_nxt = sum_c;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
    busy_nxt      = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      ops       <= '0;
      acc       <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      ops       <= ops_nxt;
      acc       <= acc_nxt;
      product   <= product_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mul_8x8_seq.sv
// Directed self-checking bench for mul_8x8_seq; drives and samples on the falling edge.
module tb_mul_8x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n;
  int seen;

  always #5 clk = ~clk;

  mul_8x8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge; on return the accepting edge has passed
  task automatic accept(input logic [7:0] av, input logic [7:0] bv);
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count further edges until out_valid, bounded
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_product", product, 16'h0000);

    // Max operands, latency measured from the accepting edge
    accept(8'hFF, 8'hFF);
    chk("ff_busy", 16'(busy), 16'h1);
    chk("ff_in_ready", 16'(in_ready), 16'h0);
    wait_done(n);
    chk("ff_latency", 16'(n), 16'd4);
    chk("ff_product", product, 16'hFE01);
    tick();
    chk("ff_idle", 16'(in_ready), 16'h1);
    chk("ff_ov_low", 16'(out_valid), 16'h0);
    chk("ff_retain", product, 16'hFE01);

    // Operand changes during MUL are ignored
    accept(8'h12, 8'h34);
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    chk("chg_latency", 16'(n), 16'd3);
    chk("chg_product", product, 16'h03A8);
    tick();

    accept(8'hA5, 8'h3C);
    wait_done(n);
    chk("a5_product", product, 16'h26AC);
    tick();

    // Backpressure holds the result
    out_ready = 1'b0;
    accept(8'h0F, 8'hF0);
    wait_done(n);
    chk("bp_product0", product, 16'h0E10);
    a = 8'h77; b = 8'h99; in_valid = 1'b1;
    repeat (10) tick();
    chk("bp_product", product, 16'h0E10);
    chk("bp_out_valid", 16'(out_valid), 16'h1);
    chk("bp_in_ready", 16'(in_ready), 16'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_idle", 16'(in_ready), 16'h1);
    chk("bp_release_ov", 16'(out_valid), 16'h0);

    // Reset at step 2 abandons the operation
    accept(8'hFF, 8'h02);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_in_ready", 16'(in_ready), 16'h1);
    chk("ra_busy", 16'(busy), 16'h0);
    chk("ra_out_valid", 16'(out_valid), 16'h0);
    chk("ra_product", product, 16'h0000);
    seen = 0;
    repeat (6) begin
      tick();
      if (out_valid) seen++;
    end
    chk("ra_no_pulse", 16'(seen), 16'h0);
    accept(8'h00, 8'hA5);
    wait_done(n);
    chk("zero_latency", 16'(n), 16'd4);
    chk("zero_product", product, 16'h0000);
    tick();

    // Back-to-back with in_valid and out_ready held high
    a = 8'h10; b = 8'h10; in_valid = 1'b1;
    tick();
    a = 8'h80; b = 8'h02;
    wait_done(n);
    chk("b2b1_latency", 16'(n), 16'd4);
    chk("b2b1_product", product, 16'h0100);
    tick();
    chk("b2b_idle", 16'(in_ready), 16'h1);
    tick();
    chk("b2b2_accepted", 16'(busy), 16'h1);
    in_valid = 1'b0;
    wait_done(n);
    chk("b2b2_latency", 16'(n), 16'd4);
    chk("b2b2_product", product, 16'h0100);
    tick();
    chk("b2b_final_idle", 16'(in_ready), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
